fir_tdm_nmux: RTL and testbench
===============================

Name: fir_tdm_nmux

Overview:
Parametrised N-channel successor to the FIR 2:1 data selector. It captures one sample from each of NUM_CH parallel channels on a common strobe and serialises them, one channel per accepted transfer, onto a single FIR datapath with a valid/ready handshake. A static mode keeps the old selector use: one channel is chosen by index and the output is registered.

Parameters:
FILTERBITWIDTH, 20, sample width in bits per channel
NUM_CH, 4, number of input channels (>= 2)
CH_BITS, 2, channel index width; 2^CH_BITS >= NUM_CH required

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
mode  input  1  0 = TDM serialise, 1 = static select
static_sel  input  CH_BITS  channel index used in static mode
in_valid  input  1  strobe: all NUM_CH channel samples valid this cycle
in_data  input  NUM_CH*FILTERBITWIDTH  packed samples, ch k at bits [k*W +: W]
out_ready  input  1  downstream accepts out_data (TDM mode only)
out_valid  output  1  out_data/out_ch valid
out_data  output  FILTERBITWIDTH  selected/serialised sample
out_ch  output  CH_BITS  channel index of out_data
out_first  output  1  out_data is channel 0 of a frame
out_last  output  1  out_data is channel NUM_CH-1 of a frame
overrun  output  1  one-cycle pulse: strobe dropped because a frame was in progress
busy  output  1  TDM frame in progress (state SEND)

Behaviour:
- All outputs driven from registers; no combinational path from any input to any output.
- Reset: state IDLE, idx 0, frame buffer 0, out_valid 0, out_data 0, out_ch 0, out_first 0, out_last 0, overrun 0, busy 0. Reset mid-frame discards the buffered frame with no overrun pulse. rst has priority over all other inputs.
- Transfer is defined as out_valid && out_ready, sampled at the clock edge.
- mode is sampled only in IDLE. A mode change during SEND takes effect after the frame completes.
- TDM, IDLE: in_valid=1 latches all of in_data into the buffer, sets idx=0 and moves to SEND. Next cycle: out_valid=1, out_ch=0, out_data=ch0, out_first=1. Latency is 1 cycle from strobe to first word.
- TDM, SEND: out_data, out_ch, out_first and out_last are held stable while out_ready=0. On a transfer, idx increments and the outputs update next cycle. out_last=1 when idx=NUM_CH-1.
- Transfer of the last channel with in_valid=0: return to IDLE. out_valid=0 next cycle; out_data holds its last value.
- Transfer of the last channel with in_valid=1: latch the new frame, idx=0, stay in SEND. ch0 of the new frame follows with no gap and no overrun.
- in_valid=1 in SEND in any other cycle: the strobe is dropped, the buffer is unchanged and overrun=1 for exactly one cycle.
- Static (mode=1, IDLE): each cycle out_valid <= in_valid, out_data <= in_data[static_sel], out_ch <= static_sel, out_first <= 1, out_last <= 1. out_ready is ignored, busy=0 and overrun=0.
- static_sel >= NUM_CH selects channel 0 and reports out_ch=0. This is the default-branch behaviour of the original selector.
- No arithmetic is performed. Data passes bit-exact and unsigned/signed agnostic.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> every output 0 and busy 0 during reset and on the cycle after release.
2. NUM_CH=4, mode=0, out_ready=1, one-cycle in_valid with ch0..3 = 20'h11111, 20'h22222, 20'h33333, 20'h44444 -> out_valid high for 4 consecutive cycles starting 1 cycle after the strobe. out_ch=0,1,2,3 with matching data, out_first only on ch0, out_last only on ch3. out_valid=0 afterwards.
3. Same frame with out_ready=0 for 3 cycles while ch1 is presented -> out_data=20'h22222 and out_ch=1 held for 3 cycles, then ch2, ch3 follow. Total of 4 transfers, nothing duplicated or skipped.
4. Second strobe (20'hA0000..20'hA0003) in the ch3 transfer cycle -> ch0=20'hA0000 presented on the next cycle, overrun stays 0. A third strobe during ch1 -> overrun pulses 1 cycle and the frame data is unchanged.
5. NUM_CH=3, mode=1: static_sel=2 with in_valid=1, ch2=20'h5A5A5 -> out_data=20'h5A5A5, out_ch=2, out_valid=1 one cycle later. static_sel=3 -> ch0 data with out_ch=0.
6. Assert rst during the ch2 transfer of a TDM frame, then a fresh strobe -> outputs clear on the reset edge. The new frame starts cleanly at ch0 with no stale data and no overrun.

Source files
------------

// File: rtl/fir_tdm_nmux_if.sv
// Stream bundle for fir_tdm_nmux: a parallel multi-channel strobe in, one serialised word out.
// A word moves only on a clock edge where out_valid && out_ready; the producer holds the word
// stable until then. in_valid is a one-cycle strobe with no backpressure.
interface fir_tdm_nmux_if #(
  parameter int FILTERBITWIDTH = 20,
  parameter int NUM_CH         = 4,
  parameter int CH_BITS        = 2
);
  logic                             in_valid;
  logic [NUM_CH*FILTERBITWIDTH-1:0] in_data;
  logic                             out_ready;
  logic                             out_valid;
  logic [FILTERBITWIDTH-1:0]        out_data;
  logic [CH_BITS-1:0]               out_ch;
  logic                             out_first;
  logic                             out_last;

  modport master (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_ch, out_first, out_last
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_ch, out_first, out_last
  );
endinterface

// File: rtl/fir_tdm_nmux.sv
// N-channel capture and time-division serialiser for the FIR datapath, with a static
// single-channel registered selector mode. The FSM state is visible on busy.
module fir_tdm_nmux #(
  parameter int FILTERBITWIDTH = 20,
  parameter int NUM_CH         = 4,
  parameter int CH_BITS        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [CH_BITS-1:0] static_sel,
  fir_tdm_nmux_if.master     bus,
  output logic               overrun,
  output logic               busy
);
  localparam int W = FILTERBITWIDTH;
  localparam logic [CH_BITS-1:0] LAST_IDX = CH_BITS'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [NUM_CH*W-1:0]   frame_q, frame_d;
  logic [CH_BITS-1:0]    idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic [W-1:0]          data_q, data_d;
  logic [CH_BITS-1:0]    ch_q, ch_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  ovr_q, ovr_d;

  logic [CH_BITS-1:0]    sel_ch;
  logic [CH_BITS-1:0]    nxt_idx;
  logic                  xfer;
  logic                  last_xfer;
  logic                  load;

  always_comb begin
    // Out-of-range static indices fall back to channel 0, as the original selector did.
    sel_ch    = ({1'b0, static_sel} < (CH_BITS+1)'(NUM_CH)) ? static_sel : '0;
    xfer      = valid_q && bus.out_ready;
    last_xfer = xfer && (idx_q == LAST_IDX);
    nxt_idx   = idx_q + 1'b1;
    load      = 1'b0;

    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    first_d = first_q;
    last_d  = last_q;
    ovr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mode) begin
          valid_d = bus.in_valid;
          data_d  = bus.in_data[int'(sel_ch)*W +: W];
          ch_d    = sel_ch;
          first_d = 1'b1;
          last_d  = 1'b1;
        end else if (bus.in_valid) begin
          load = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      SEND: begin
        if (last_xfer) begin
          // A strobe coinciding with the final transfer chains the next frame without a gap.
          if (bus.in_valid) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else begin
          if (xfer) begin
            idx_d   = nxt_idx;
            data_d  = frame_q[int'(nxt_idx)*W +: W];
            ch_d    = nxt_idx;
            first_d = 1'b0;
            last_d  = (nxt_idx == LAST_IDX);
          end
          ovr_d = bus.in_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = SEND;
      frame_d = bus.in_data;
      idx_d   = '0;
      valid_d = 1'b1;
      data_d  = bus.in_data[W-1:0];
      ch_d    = '0;
      first_d = 1'b1;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      first_q <= first_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q == SEND);
endmodule

// File: tb/tb_fir_tdm_nmux.sv
// Bench for fir_tdm_nmux: a 4-channel instance in TDM/mixed mode and a 3-channel instance
// in static mode, both checked every cycle against a queue-based reference model.
module tb_fir_tdm_nmux;
  localparam int W = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       mode4, mode3;
  logic [1:0] sel4, sel3;
  logic       ovr4, ovr3, busy4, busy3;

  fir_tdm_nmux_if #(.FILTERBITWIDTH(W), .NUM_CH(4), .CH_BITS(2)) b4 ();
  fir_tdm_nmux_if #(.FILTERBITWIDTH(W), .NUM_CH(3), .CH_BITS(2)) b3 ();

  fir_tdm_nmux #(.FILTERBITWIDTH(W), .NUM_CH(4), .CH_BITS(2)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .static_sel(sel4), .bus(b4),
    .overrun(ovr4), .busy(busy4)
  );

  fir_tdm_nmux #(.FILTERBITWIDTH(W), .NUM_CH(3), .CH_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .static_sel(sel3), .bus(b3),
    .overrun(ovr3), .busy(busy3)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   ch;
    logic         first;
    logic         last;
  } word_t;

  word_t        exp_q[$];   // words of the current frame still owed, front = on the bus
  word_t        cur;
  logic         cur_valid;
  logic         exp_ovr;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic [1:0]   s_ch;
  logic         s_fl;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < 4; k++) begin
      word_t w;
      w.data  = b4.in_data[k*W +: W];
      w.ch    = 2'(k);
      w.first = (k == 0);
      w.last  = (k == 3);
      exp_q.push_back(w);
    end
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_edge();
    int k;
    if (rst) begin
      exp_q.delete();
      cur = '0; cur_valid = 1'b0; exp_ovr = 1'b0;
      s_valid = 1'b0; s_data = '0; s_ch = '0; s_fl = 1'b0;
    end else begin
      exp_ovr = 1'b0;
      if (exp_q.size() != 0) begin
        if (b4.out_ready) void'(exp_q.pop_front());
        if (b4.in_valid) begin
          if (exp_q.size() == 0) push_frame();
          else exp_ovr = 1'b1;
        end
        if (exp_q.size() != 0) begin cur = exp_q[0]; cur_valid = 1'b1; end
        else cur_valid = 1'b0;
      end else if (mode4) begin
        k = int'(sel4);
        cur_valid = b4.in_valid;
        cur.data  = b4.in_data[k*W +: W];
        cur.ch    = sel4;
        cur.first = 1'b1;
        cur.last  = 1'b1;
      end else if (b4.in_valid) begin
        push_frame();
        cur = exp_q[0]; cur_valid = 1'b1;
      end else begin
        cur_valid = 1'b0;
      end
      k       = (sel3 < 2'd3) ? int'(sel3) : 0;
      s_valid = b3.in_valid;
      s_data  = b3.in_data[k*W +: W];
      s_ch    = 2'(k);
      s_fl    = 1'b1;
    end
  endtask

  task automatic compare();
    check("t_valid",   64'(b4.out_valid), 64'(cur_valid));
    check("t_data",    64'(b4.out_data),  64'(cur.data));
    check("t_ch",      64'(b4.out_ch),    64'(cur.ch));
    check("t_first",   64'(b4.out_first), 64'(cur.first));
    check("t_last",    64'(b4.out_last),  64'(cur.last));
    check("t_overrun", 64'(ovr4),         64'(exp_ovr));
    check("t_busy",    64'(busy4),        64'(exp_q.size() != 0));
    check("s_valid",   64'(b3.out_valid), 64'(s_valid));
    check("s_data",    64'(b3.out_data),  64'(s_data));
    check("s_ch",      64'(b3.out_ch),    64'(s_ch));
    check("s_first",   64'(b3.out_first), 64'(s_fl));
    check("s_last",    64'(b3.out_last),  64'(s_fl));
    check("s_overrun", 64'(ovr3),         64'(1'b0));
    check("s_busy",    64'(busy3),        64'(1'b0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    cyc++;
  endtask

  task automatic drv(input logic v, input logic [4*W-1:0] d, input logic r);
    b4.in_valid  = v;
    b4.in_data   = d;
    b4.out_ready = r;
    step();
  endtask

  function automatic logic [4*W-1:0] mkf(input logic [W-1:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [4*W-1:0] rnd4();
    return {16'($urandom()), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [4*W-1:0] fa, fb;
    rst = 1'b1; mode4 = 1'b0; mode3 = 1'b1; sel4 = '0; sel3 = '0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;

    // Reset with random activity on the inputs.
    repeat (2) begin
      b3.in_valid = 1'b1; b3.in_data = {28'($urandom()), $urandom()}; sel3 = 2'($urandom_range(0, 3));
      drv(1'b1, rnd4(), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    b3.in_valid = 1'b0;
    drv(1'b0, '0, 1'b1);

    // Single frame, always ready; static instance selects ch2 then an out-of-range index.
    b3.in_valid = 1'b1; sel3 = 2'd2;
    b3.in_data  = {20'h5A5A5, 20'h0BEEF, 20'h0CAFE};
    drv(1'b1, mkf(20'h11111, 20'h22222, 20'h33333, 20'h44444), 1'b1);
    sel3 = 2'd3;
    drv(1'b0, '0, 1'b1);
    b3.in_valid = 1'b0;
    repeat (5) drv(1'b0, '0, 1'b1);

    // Backpressure while ch1 is presented.
    drv(1'b1, mkf(20'h11111, 20'h22222, 20'h33333, 20'h44444), 1'b1);
    drv(1'b0, '0, 1'b1);
    repeat (3) drv(1'b0, '0, 1'b0);
    repeat (4) drv(1'b0, '0, 1'b1);

    // Chained frame on the last transfer, then a strobe mid-frame.
    fa = mkf(20'h11111, 20'h22222, 20'h33333, 20'h44444);
    fb = mkf(20'hA0000, 20'hA0001, 20'hA0002, 20'hA0003);
    drv(1'b1, fa, 1'b1);
    repeat (3) drv(1'b0, '0, 1'b1);
    drv(1'b1, fb, 1'b1);
    drv(1'b0, '0, 1'b1);
    drv(1'b1, rnd4(), 1'b1);
    repeat (5) drv(1'b0, '0, 1'b1);

    // Reset while ch2 is on the bus, then a fresh frame.
    drv(1'b1, fa, 1'b1);
    repeat (2) drv(1'b0, '0, 1'b1);
    rst = 1'b1;
    drv(1'b0, '0, 1'b1);
    rst = 1'b0;
    drv(1'b1, fb, 1'b1);
    repeat (5) drv(1'b0, '0, 1'b1);

    // Mode switched to static mid-frame only takes effect once the frame is done.
    drv(1'b1, fa, 1'b1);
    mode4 = 1'b1; sel4 = 2'd3;
    repeat (3) drv(1'b0, rnd4(), 1'b1);
    repeat (3) drv(1'b1, rnd4(), 1'b0);
    mode4 = 1'b0;
    repeat (2) drv(1'b0, '0, 1'b1);

    // Randomised traffic on both instances.
    repeat (3000) begin
      rst          = ($urandom_range(0, 299) == 0);
      mode4        = ($urandom_range(0, 11) == 0);
      sel4         = 2'($urandom_range(0, 3));
      sel3         = 2'($urandom_range(0, 3));
      b3.in_valid  = 1'($urandom_range(0, 1));
      b3.in_data   = {28'($urandom()), $urandom()};
      b3.out_ready = 1'($urandom_range(0, 1));
      drv(($urandom_range(0, 3) == 0), rnd4(), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
